tree_node_walker: RTL and testbench

- Decision-tree traversal engine directly downstream of the feature mux in the Random Forest classifier datapath.
- Holds one tree's node table, registers a 256-bit input sample, and drives the sample and a feature index into the mux.
- Consumes the selected feature, compares it against the node threshold, and walks left or right until it reaches a leaf.
- Emits the leaf class through a valid/ready output. One instance per tree; a later voting stage consumes the class.

---
 rtl/tree_node_walker_if.sv | 33 +++
 rtl/tree_node_walker.sv | 123 ++++++++++++
 tb/tb_tree_node_walker.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tree_node_walker_if.sv
// Bundle of the node-table write port, the sample/result handshakes and the
// feature-mux link for one tree_node_walker. The walker uses the slave side.
interface tree_node_walker_if #(
  parameter int FEAT_W   = 16,
  parameter int NUM_FEAT = 16,
  parameter int ADDR_W   = 6,
  parameter int CLASS_W  = 4,
  parameter int NODE_W   = 37
);
  logic                       node_we;
  logic [ADDR_W-1:0]          node_waddr;
  logic [NODE_W-1:0]          node_wdata;
  logic                       s_valid;
  logic                       s_ready;
  logic [FEAT_W*NUM_FEAT-1:0] s_sample;
  logic [FEAT_W*NUM_FEAT-1:0] mux_d;
  logic [7:0]                 mux_sel;
  logic [31:0]                mux_y;
  logic                       m_valid;
  logic                       m_ready;
  logic [CLASS_W-1:0]         m_class;
  logic                       m_err;

  modport slave (
    input  node_we, node_waddr, node_wdata, s_valid, s_sample, mux_y, m_ready,
    output s_ready, mux_d, mux_sel, m_valid, m_class, m_err
  );

  modport master (
    output node_we, node_waddr, node_wdata, s_valid, s_sample, mux_y, m_ready,
    input  s_ready, mux_d, mux_sel, m_valid, m_class, m_err
  );
endinterface

// File: rtl/tree_node_walker.sv
// Walks one decision tree per accepted sample: fetch node, compare the muxed
// feature with the threshold, follow a child until a leaf or the step limit.
module tree_node_walker #(
  parameter int FEAT_W    = 16,
  parameter int NUM_FEAT  = 16,
  parameter int ADDR_W    = 6,
  parameter int CLASS_W   = 4,
  parameter int MAX_STEPS = 16,
  parameter int NODE_W    = 37
) (
  input logic               clk,
  input logic               rst_n,
  tree_node_walker_if.slave bus
);

  localparam int STEP_W   = $clog2(MAX_STEPS);
  localparam int SAMPLE_W = FEAT_W * NUM_FEAT;

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [NODE_W-1:0]   node_mem [0:2**ADDR_W-1];
  logic [NODE_W-1:0]   node_q;
  logic [ADDR_W-1:0]   ptr;
  logic [STEP_W-1:0]   steps;
  logic                armed;
  logic [SAMPLE_W-1:0] sample_q;
  logic [CLASS_W-1:0]  class_q;
  logic                err_q;

  logic                leaf;
  logic [3:0]          feat_idx;
  logic [FEAT_W-1:0]   threshold;
  logic [ADDR_W-1:0]   left_ptr;
  logic [ADDR_W-1:0]   right_ptr;
  logic [CLASS_W-1:0]  leaf_class;
  logic                accept;
  logic                go_left;
  logic                last_step;
  logic                unused_mux_hi;

  assign leaf       = node_q[NODE_W-1];
  assign feat_idx   = node_q[NODE_W-2 -: 4];
  assign threshold  = node_q[2*ADDR_W+CLASS_W +: FEAT_W];
  assign left_ptr   = node_q[ADDR_W+CLASS_W +: ADDR_W];
  assign right_ptr  = node_q[CLASS_W +: ADDR_W];
  assign leaf_class = node_q[CLASS_W-1:0];

  assign accept        = bus.s_valid && bus.s_ready;
  assign go_left       = bus.mux_y[FEAT_W-1:0] <= threshold;
  assign last_step     = steps == STEP_W'(MAX_STEPS - 1);
  assign unused_mux_hi = ^bus.mux_y[31:FEAT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = FETCH;
      FETCH:   state_nxt = EVAL;
      EVAL:    if (leaf || last_step) state_nxt = DONE;
               else                   state_nxt = FETCH;
      DONE:    if (bus.m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // s_ready depends only on registered state, so m_ready never reaches it combinationally.
  always_comb begin
    bus.s_ready = armed && (state == IDLE);
    bus.m_valid = (state == DONE);
    bus.mux_sel = (state == EVAL) ? {4'b0000, feat_idx} : 8'h00;
    bus.mux_d   = sample_q;
    bus.m_class = class_q;
    bus.m_err   = err_q;
  end

  // Holds s_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      ptr      <= '0;
      steps    <= '0;
      class_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sample_q <= bus.s_sample;
          ptr      <= '0;
          steps    <= '0;
        end
        EVAL: if (leaf) begin
          class_q <= leaf_class;
          err_q   <= 1'b0;
        end else if (last_step) begin
          class_q <= '0;
          err_q   <= 1'b1;
        end else begin
          ptr   <= go_left ? left_ptr : right_ptr;
          steps <= steps + STEP_W'(1);
        end
        default: ;
      endcase
    end
  end

  // The table is deliberately outside the reset domain so a loaded tree survives reset.
  always_ff @(posedge clk) begin
    if (bus.node_we && (state == IDLE)) node_mem[bus.node_waddr] <= bus.node_wdata;
    if (state == FETCH) node_q <= node_mem[ptr];
  end

endmodule

// File: tb/tb_tree_node_walker.sv
// Bench for tree_node_walker: directed corner sequences, a vector table and
// random trees checked against a node-by-node behavioural walk model.
module tb_tree_node_walker;

  localparam int FEAT_W    = 16;
  localparam int NUM_FEAT  = 16;
  localparam int ADDR_W    = 6;
  localparam int CLASS_W   = 4;
  localparam int MAX_STEPS = 16;
  localparam int NODE_W    = 37;

  typedef struct {
    logic        leaf;
    logic [3:0]  feat;
    logic [15:0] thr;
    logic [5:0]  left;
    logic [5:0]  right;
    logic [3:0]  cls;
  } node_t;

  typedef struct {
    string       name;
    logic [15:0] featVal;
    logic [3:0]  expCls;
    int          expCyc;
    logic [7:0]  expSel;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    checks = 0;
  int    errors = 0;
  node_t tbl [64];

  always #5 clk = ~clk;

  tree_node_walker_if #(.FEAT_W(FEAT_W), .NUM_FEAT(NUM_FEAT), .ADDR_W(ADDR_W),
                        .CLASS_W(CLASS_W), .NODE_W(NODE_W)) bus ();

  tree_node_walker #(.FEAT_W(FEAT_W), .NUM_FEAT(NUM_FEAT), .ADDR_W(ADDR_W),
                     .CLASS_W(CLASS_W), .MAX_STEPS(MAX_STEPS), .NODE_W(NODE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Feature mux stand-in; the upper half carries junk the walker must ignore.
  assign bus.mux_y = {16'hA5A5, bus.mux_d[16*bus.mux_sel[3:0] +: 16]};

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  function automatic node_t mkNode(input logic leaf, input logic [3:0] feat, input logic [15:0] thr,
                                   input logic [5:0] left, input logic [5:0] right, input logic [3:0] cls);
    node_t n;
    n.leaf = leaf; n.feat = feat; n.thr = thr; n.left = left; n.right = right; n.cls = cls;
    return n;
  endfunction

  function automatic logic [36:0] packNode(input node_t n);
    return {n.leaf, n.feat, n.thr, n.left, n.right, n.cls};
  endfunction

  function automatic vec_t mkVec(input string name, input logic [15:0] v, input logic [3:0] c,
                                 input int cyc, input logic [7:0] sel);
    vec_t t;
    t.name = name; t.featVal = v; t.expCls = c; t.expCyc = cyc; t.expSel = sel;
    return t;
  endfunction

  function automatic logic [255:0] mkSample(input int idx, input logic [15:0] v);
    logic [255:0] s;
    for (int i = 0; i < 8; i++) s[32*i +: 32] = $urandom;
    s[16*idx +: 16] = v;
    return s;
  endfunction

  // Reference walk: cycle numbers count from the accept edge as cycle 0.
  function automatic void modelWalk(input logic [255:0] smp, output logic [3:0] cls,
                                    output logic err, output int cyc);
    int p = 0;
    logic [15:0] f;
    cls = 0; err = 0; cyc = 0;
    for (int s = 0; s < MAX_STEPS; s++) begin
      if (tbl[p].leaf) begin
        cls = tbl[p].cls; err = 0; cyc = 2*s + 3;
        return;
      end
      if (s == MAX_STEPS - 1) begin
        cls = 0; err = 1; cyc = 2*MAX_STEPS + 1;
        return;
      end
      f = smp[16*tbl[p].feat +: 16];
      p = (f <= tbl[p].thr) ? int'(tbl[p].left) : int'(tbl[p].right);
    end
  endfunction

  task automatic writeNode(input int addr, input node_t n);
    @(negedge clk);
    bus.node_we    = 1'b1;
    bus.node_waddr = 6'(addr);
    bus.node_wdata = packNode(n);
    @(negedge clk);
    bus.node_we = 1'b0;
    tbl[addr] = n;
  endtask

  // Accepts one sample and returns once m_valid is seen (or the bound expires).
  task automatic applyStimulus(input logic [255:0] smp, input int busyCyc, input bit wrAtAccept,
                               input node_t wrNode, output int cyc, output logic [3:0] cls,
                               output logic err, output logic [7:0] evalSel);
    int n = 0;
    @(negedge clk);
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("s_ready wait", 0, 1);
    bus.s_sample = smp;
    bus.s_valid  = 1'b1;
    if (wrAtAccept) begin
      bus.node_we    = 1'b1;
      bus.node_waddr = '0;
      bus.node_wdata = packNode(wrNode);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.node_we = 1'b0;
    cyc = 1;
    evalSel = '0;
    while (!bus.m_valid && cyc < 100) begin
      if (cyc == 2) evalSel = bus.mux_sel;
      if (cyc == busyCyc) begin
        bus.node_we    = 1'b1;
        bus.node_waddr = '0;
        bus.node_wdata = packNode(mkNode(1'b1, 4'd0, 16'h0, 6'd0, 6'd0, 4'd7));
      end
      @(negedge clk);
      bus.node_we = 1'b0;
      cyc++;
    end
    cls = bus.m_class;
    err = bus.m_err;
  endtask

  task automatic releaseResult();
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
  endtask

  task automatic doRun(input string name, input logic [255:0] smp, input int busyCyc,
                       input bit wr, input node_t wrN, input logic [3:0] expCls,
                       input logic expErr, input int expCyc, input logic [7:0] expSel);
    int cyc;
    logic [3:0] cls;
    logic err;
    logic [7:0] sel;
    applyStimulus(smp, busyCyc, wr, wrN, cyc, cls, err, sel);
    checkOutput($sformatf("%s class", name), 256'(cls), 256'(expCls));
    checkOutput($sformatf("%s err", name), 256'(err), 256'(expErr));
    checkOutput($sformatf("%s cycle", name), 256'(cyc), 256'(expCyc));
    checkOutput($sformatf("%s sel", name), 256'(sel), 256'(expSel));
    releaseResult();
  endtask

  task automatic checkAllZero(input string name);
    checkOutput($sformatf("%s s_ready", name), 256'(bus.s_ready), 0);
    checkOutput($sformatf("%s m_valid", name), 256'(bus.m_valid), 0);
    checkOutput($sformatf("%s m_class", name), 256'(bus.m_class), 0);
    checkOutput($sformatf("%s m_err", name), 256'(bus.m_err), 0);
    checkOutput($sformatf("%s mux_sel", name), 256'(bus.mux_sel), 0);
    checkOutput($sformatf("%s mux_d", name), bus.mux_d, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    node_t none;
    vec_t vecs [4];
    logic [255:0] smp;
    logic [255:0] heldD;
    logic [3:0] cls, expCls, heldCls;
    logic err, expErr;
    logic [7:0] sel;
    int cyc, expCyc, bad;

    none = mkNode(1'b0, 4'd0, 16'h0, 6'd0, 6'd0, 4'd0);
    bus.node_we = 1'b0; bus.node_waddr = '0; bus.node_wdata = '0;
    bus.s_valid = 1'b0; bus.s_sample = '0; bus.m_ready = 1'b0;

    // Reset state, then s_ready rising one edge after release.
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("s_ready before first edge", 256'(bus.s_ready), 0);
    @(negedge clk);
    checkOutput("s_ready after first edge", 256'(bus.s_ready), 1);

    writeNode(0, mkNode(1'b1, 4'd0, 16'h0, 6'd0, 6'd0, 4'd5));
    doRun("root leaf", mkSample(0, 16'h1234), 0, 1'b0, none, 4'd5, 1'b0, 3, 8'h00);

    // Write and accept on the same edge: the walk must see the new root.
    doRun("write at accept", mkSample(0, 16'h0), 0, 1'b1,
          mkNode(1'b1, 4'd0, 16'h0, 6'd0, 6'd0, 4'd6), 4'd6, 1'b0, 3, 8'h00);
    tbl[0] = mkNode(1'b1, 4'd0, 16'h0, 6'd0, 6'd0, 4'd6);

    writeNode(0, mkNode(1'b0, 4'd3, 16'h0100, 6'd1, 6'd2, 4'd0));
    writeNode(1, mkNode(1'b1, 4'd0, 16'h0, 6'd0, 6'd0, 4'd1));
    writeNode(2, mkNode(1'b1, 4'd0, 16'h0, 6'd0, 6'd0, 4'd2));
    vecs[0] = mkVec("equal",   16'h0100, 4'd1, 5, 8'h03);
    vecs[1] = mkVec("above",   16'h0101, 4'd2, 5, 8'h03);
    vecs[2] = mkVec("zero",    16'h0000, 4'd1, 5, 8'h03);
    vecs[3] = mkVec("maximum", 16'hFFFF, 4'd2, 5, 8'h03);
    for (int i = 0; i < 4; i++)
      doRun(vecs[i].name, mkSample(3, vecs[i].featVal), 0, 1'b0, none,
            vecs[i].expCls, 1'b0, vecs[i].expCyc, vecs[i].expSel);

    // Backpressure: result held while m_ready stays low and a new sample waits.
    smp = mkSample(3, 16'h0200);
    applyStimulus(smp, 0, 1'b0, none, cyc, cls, err, sel);
    checkOutput("bp class", 256'(cls), 2);
    heldCls = bus.m_class;
    heldD = bus.mux_d;
    bus.s_sample = mkSample(3, 16'h0001);
    bus.s_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.m_valid !== 1'b1 || bus.m_class !== heldCls || bus.s_ready !== 1'b0) bad++;
    end
    checkOutput("bp held cycles", 256'(bad), 0);
    checkOutput("bp sample not taken", bus.mux_d, smp);
    checkOutput("bp held data", heldD, smp);
    bus.m_ready = 1'b1;
    #1 checkOutput("bp s_ready same cycle", 256'(bus.s_ready), 0);
    @(negedge clk);
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b0;
    checkOutput("bp s_ready next cycle", 256'(bus.s_ready), 1);
    checkOutput("bp m_valid dropped", 256'(bus.m_valid), 0);

    // Write while busy is ignored, both in this walk and the next.
    doRun("busy write", mkSample(3, 16'h0100), 2, 1'b0, none, 4'd1, 1'b0, 5, 8'h03);
    doRun("after busy write", mkSample(3, 16'h0100), 0, 1'b0, none, 4'd1, 1'b0, 5, 8'h03);

    // Reset in the middle of a walk.
    @(negedge clk);
    bus.s_sample = mkSample(3, 16'h0300);
    bus.s_valid = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre-reset sel", 256'(bus.mux_sel), 8'h03);
    #2 rst_n = 1'b0;
    #1 checkAllZero("mid-walk reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("s_ready held after release", 256'(bus.s_ready), 0);
    @(negedge clk);
    checkOutput("no stale m_valid", 256'(bus.m_valid), 0);
    doRun("after reset", mkSample(3, 16'h0100), 0, 1'b0, none, 4'd1, 1'b0, 5, 8'h03);

    writeNode(0, mkNode(1'b0, 4'd5, 16'h8000, 6'd0, 6'd0, 4'd9));
    doRun("loop abort", mkSample(5, 16'h0042), 0, 1'b0, none, 4'd0, 1'b1, 33, 8'h05);

    writeNode(0, mkNode(1'b0, 4'd15, 16'hFFFF, 6'd1, 6'd2, 4'd0));
    writeNode(1, mkNode(1'b1, 4'd0, 16'h0, 6'd0, 6'd0, 4'd3));
    writeNode(2, mkNode(1'b1, 4'd0, 16'h0, 6'd0, 6'd0, 4'd4));
    doRun("index 15", mkSample(15, 16'hFFFF), 0, 1'b0, none, 4'd3, 1'b0, 5, 8'h0F);

    // Random trees against the reference walk; the second round is deeper.
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < 64; a++)
        writeNode(a, mkNode($urandom_range(0, (r == 0) ? 1 : 4) == 0, 4'($urandom),
                            16'($urandom), 6'($urandom), 6'($urandom), 4'($urandom)));
      for (int t = 0; t < 30; t++) begin
        smp = mkSample(0, 16'($urandom));
        modelWalk(smp, expCls, expErr, expCyc);
        applyStimulus(smp, 0, 1'b0, none, cyc, cls, err, sel);
        checkOutput($sformatf("rand %0d.%0d class", r, t), 256'(cls), 256'(expCls));
        checkOutput($sformatf("rand %0d.%0d err", r, t), 256'(err), 256'(expErr));
        checkOutput($sformatf("rand %0d.%0d cycle", r, t), 256'(cyc), 256'(expCyc));
        checkOutput($sformatf("rand %0d.%0d sel", r, t), 256'(sel), 256'({4'b0000, tbl[0].feat}));
        releaseResult();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
